// File: rtl/sha256_round_sequencer_pkg.sv
// Shared SHA-256 constants, word width and sequencer state encoding.
// Imported by the round sequencer and its sigma datapath.
package sha256_round_sequencer_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } seqState_t;

    localparam logic [31:0] SHA256_IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] SHA256_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_sigma.sv
// Combinational SHA-256 Sigma functions built from fixed wire rotations.
// S0/S1 serve the compression round, s0/s1 serve the message schedule.
module sha256_sigma
    import sha256_round_sequencer_pkg::*;
(
    input  logic [WORD_W-1:0] aIn,
    input  logic [WORD_W-1:0] eIn,
    input  logic [WORD_W-1:0] s0In,
    input  logic [WORD_W-1:0] s1In,
    output logic [WORD_W-1:0] bigS0,
    output logic [WORD_W-1:0] bigS1,
    output logic [WORD_W-1:0] smallS0,
    output logic [WORD_W-1:0] smallS1
);

    assign bigS0 = {aIn[1:0], aIn[31:2]}
                 ^ {aIn[12:0], aIn[31:13]}
                 ^ {aIn[21:0], aIn[31:22]};

    assign bigS1 = {eIn[5:0], eIn[31:6]}
                 ^ {eIn[10:0], eIn[31:11]}
                 ^ {eIn[24:0], eIn[31:25]};

    // Schedule sigmas mix two rotations with a logical shift.
    assign smallS0 = {s0In[6:0], s0In[31:7]}
                   ^ {s0In[17:0], s0In[31:18]}
                   ^ {3'b000, s0In[31:3]};

    assign smallS1 = {s1In[16:0], s1In[31:17]}
                   ^ {s1In[18:0], s1In[31:19]}
                   ^ {10'b0, s1In[31:10]};

endmodule

// File: rtl/sha256_round_sequencer.sv
// One-round-per-clock SHA-256 compression sequencer with valid/ready
// on both the block input and the digest output.
module sha256_round_sequencer
    import sha256_round_sequencer_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inValid,
    output logic         inReady,
    input  logic [511:0] blockIn,
    input  logic [255:0] hashIn,
    output logic         outValid,
    input  logic         outReady,
    output logic [255:0] digestOut,
    output logic         busy,
    output logic [5:0]   roundIndex
);

    seqState_t state, nextState;

    logic [WORD_W-1:0] hReg [8];
    logic [WORD_W-1:0] wv   [8];
    logic [WORD_W-1:0] wWin [16];
    logic [5:0]        tCount;

    logic [WORD_W-1:0] bigS0, bigS1, smallS0, smallS1;
    logic [WORD_W-1:0] chVal, majVal, t1, t2, newW;
    logic              accept, lastRound;

    sha256_sigma uSigma (
        .aIn     (wv[0]),
        .eIn     (wv[4]),
        .s0In    (wWin[1]),
        .s1In    (wWin[14]),
        .bigS0   (bigS0),
        .bigS1   (bigS1),
        .smallS0 (smallS0),
        .smallS1 (smallS1)
    );

    assign accept    = inValid && inReady;
    assign lastRound = (tCount == 6'(ROUNDS - 1));

    assign chVal  = (wv[4] & wv[5]) ^ (~wv[4] & wv[6]);
    assign majVal = (wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]);
    assign t1     = wv[7] + bigS1 + chVal + SHA256_K[tCount] + wWin[0];
    assign t2     = bigS0 + majVal;
    // wWin[j] holds W[t+j], so the word entering slot 15 is W[t+16].
    assign newW   = smallS1 + wWin[9] + smallS0 + wWin[0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:  if (accept) nextState = ROUND;
            ROUND: if (lastRound) nextState = FINAL;
            FINAL: nextState = DONE;
            DONE:  if (outReady) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tCount <= '0;
            for (int i = 0; i < 8; i++) begin
                hReg[i] <= '0;
                wv[i]   <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                wWin[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        tCount <= '0;
                        for (int i = 0; i < 8; i++) begin
                            hReg[i] <= hashIn[255 - 32*i -: 32];
                            wv[i]   <= hashIn[255 - 32*i -: 32];
                        end
                        for (int i = 0; i < 16; i++) begin
                            wWin[i] <= blockIn[511 - 32*i -: 32];
                        end
                    end
                end
                ROUND: begin
                    wv[0] <= t1 + t2;
                    wv[1] <= wv[0];
                    wv[2] <= wv[1];
                    wv[3] <= wv[2];
                    wv[4] <= wv[3] + t1;
                    wv[5] <= wv[4];
                    wv[6] <= wv[5];
                    wv[7] <= wv[6];
                    for (int i = 0; i < 15; i++) begin
                        wWin[i] <= wWin[i+1];
                    end
                    wWin[15] <= newW;
                    tCount   <= lastRound ? 6'd0 : tCount + 6'd1;
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) begin
                        hReg[i] <= hReg[i] + wv[i];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        digestOut = '0;
        for (int i = 0; i < 8; i++) begin
            digestOut[255 - 32*i -: 32] = hReg[i];
        end
    end

    assign inReady    = (state == IDLE);
    assign outValid   = (state == DONE);
    assign busy       = (state == ROUND) || (state == FINAL);
    assign roundIndex = tCount;

endmodule

// File: tb/tb_sha256_round_sequencer.sv
// Scoreboard bench for the SHA-256 round sequencer: known vectors,
// randomized blocks against a behavioural model, reset and backpressure.
module tb_sha256_round_sequencer;
    import sha256_round_sequencer_pkg::*;

    localparam int ROUNDS = 64;

    logic         clock = 1'b0;
    logic         reset;
    logic         inValid;
    logic         inReady;
    logic [511:0] blockIn;
    logic [255:0] hashIn;
    logic         outValid;
    logic         outReady;
    logic [255:0] digestOut;
    logic         busy;
    logic [5:0]   roundIndex;

    logic [31:0] sigA, sigE, sigW1, sigW14;
    logic [31:0] sigBigS0, sigBigS1, sigSmallS0, sigSmallS1;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    typedef struct {
        logic [255:0] digest;
        int           acceptCycle;
    } expItem_t;

    expItem_t sb[$];

    sha256_round_sequencer #(.ROUNDS(ROUNDS)) dut (
        .clock      (clock),
        .reset      (reset),
        .inValid    (inValid),
        .inReady    (inReady),
        .blockIn    (blockIn),
        .hashIn     (hashIn),
        .outValid   (outValid),
        .outReady   (outReady),
        .digestOut  (digestOut),
        .busy       (busy),
        .roundIndex (roundIndex)
    );

    sha256_sigma uSigmaTb (
        .aIn     (sigA),
        .eIn     (sigE),
        .s0In    (sigW1),
        .s1In    (sigW14),
        .bigS0   (sigBigS0),
        .bigS1   (sigBigS1),
        .smallS0 (sigSmallS0),
        .smallS1 (sigSmallS1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle = cycle + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: full 64-entry schedule array and textbook rounds.
    function automatic logic [31:0] rotr(logic [31:0] x, int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] fS0(logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] fS1(logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] fs0(logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] fs1(logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [255:0] refCompress(logic [511:0] blk,
                                                 logic [255:0] hin);
        logic [31:0] w [64];
        logic [31:0] h [8];
        logic [31:0] a, b, c, d, e, f, g, hh, x1, x2;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = fs1(w[t-2]) + w[t-7] + fs0(w[t-15]) + w[t-16];
        for (int i = 0; i < 8; i++) h[i] = hin[255 - 32*i -: 32];
        a = h[0]; b = h[1]; c = h[2]; d = h[3];
        e = h[4]; f = h[5]; g = h[6]; hh = h[7];
        for (int t = 0; t < ROUNDS; t++) begin
            x1 = hh + fS1(e) + ((e & f) ^ (~e & g)) + SHA256_K[t] + w[t];
            x2 = fS0(a) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + x1;
            d = c; c = b; b = a; a = x1 + x2;
        end
        res = {h[0] + a, h[1] + b, h[2] + c, h[3] + d,
               h[4] + e, h[5] + f, h[6] + g, h[7] + hh};
        return res;
    endfunction

    function automatic logic [511:0] randBlock();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] randHash();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: latency on rising outValid, digest on each handshake.
    logic prevValid = 1'b0;
    logic prevHs    = 1'b0;
    expItem_t popped;

    always @(negedge clock) begin
        if (!reset) begin
            if (prevHs)
                check("doneOneCycle", 256'({outValid, inReady}), 256'(2'b01));
            if (outValid && !prevValid) begin
                if (sb.size() == 0)
                    check("spuriousValid", 256'(1), 256'(0));
                else
                    check("latency", 256'(cycle - sb[0].acceptCycle),
                          256'(ROUNDS + 1));
            end
            if (outValid && outReady) begin
                if (sb.size() == 0) begin
                    check("unexpectedDigest", 256'(1), 256'(0));
                end else begin
                    popped = sb.pop_front();
                    check("digest", digestOut, popped.digest);
                end
            end
        end
        prevValid = outValid && !reset;
        prevHs    = outValid && outReady && !reset;
    end

    task automatic sendBlock(logic [511:0] blk, logic [255:0] hin,
                             logic [255:0] exp, bit doPush);
        int n = 0;
        @(negedge clock);
        while (!inReady && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (!inReady) begin
            check("acceptTimeout", 256'(inReady), 256'(1));
            return;
        end
        blockIn = blk;
        hashIn  = hin;
        inValid = 1'b1;
        @(posedge clock);
        #1;
        if (doPush) sb.push_back('{exp, cycle});
        inValid = 1'b0;
    endtask

    task automatic waitRound(int idx);
        int n = 0;
        @(negedge clock);
        while (!(busy && roundIndex == 6'(idx)) && n < 150) begin
            @(negedge clock);
            n++;
        end
        check("reachRound", 256'(roundIndex), 256'(idx));
    endtask

    task automatic pulseAt(int idx);
        waitRound(idx);
        blockIn = randBlock();
        hashIn  = randHash();
        inValid = 1'b1;
        check("busyInReady", 256'(inReady), 256'(0));
        @(negedge clock);
        inValid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clock);
        while (!(sb.size() == 0 && inReady) && n < 400) begin
            @(negedge clock);
            n++;
        end
        check("drain", 256'(sb.size()), 256'(0));
        repeat (2) @(negedge clock);
    endtask

    logic [255:0] iv;
    logic [511:0] abcBlk, blk1, blk2, blkR;
    logic [255:0] abcExp, twoExp, d1, hR;

    initial begin
        for (int i = 0; i < 8; i++) iv[255 - 32*i -: 32] = SHA256_IV[i];
        abcBlk = {32'h61626380, 448'b0, 32'h00000018};
        abcExp = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
        twoExp = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
        blk1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        blk2 = {448'b0, 64'h1c0};

        reset = 1'b1;
        inValid = 1'b0;
        outReady = 1'b1;
        blockIn = '0;
        hashIn = '0;
        sigA = '0; sigE = '0; sigW1 = '0; sigW14 = '0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rstInReady", 256'(inReady), 256'(1));
        check("rstOutValid", 256'(outValid), 256'(0));
        check("rstBusy", 256'(busy), 256'(0));
        check("rstRound", 256'(roundIndex), 256'(0));
        check("rstDigest", digestOut, 256'(0));
        reset = 1'b0;

        // Sigma unit: rotation spot values and random comparisons.
        sigE = 32'h00000800; #1;
        check("sigS1_800", 256'(sigBigS1), 256'(fS1(32'h00000800)));
        sigE = 32'h00000001; #1;
        check("sigS1_1", 256'(sigBigS1), 256'(fS1(32'h00000001)));
        sigE = 32'h510e527f; #1;
        check("sigS1_iv4", 256'(sigBigS1), 256'(32'h3587272b));
        for (int i = 0; i < 4; i++) begin
            sigA = $urandom; sigE = $urandom;
            sigW1 = $urandom; sigW14 = $urandom;
            #1;
            check("sigS0", 256'(sigBigS0), 256'(fS0(sigA)));
            check("sigS1", 256'(sigBigS1), 256'(fS1(sigE)));
            check("sigs0", 256'(sigSmallS0), 256'(fs0(sigW1)));
            check("sigs1", 256'(sigSmallS1), 256'(fs1(sigW14)));
        end

        // "abc" single block.
        sendBlock(abcBlk, iv, abcExp, 1'b1);
        drain();

        // Two-block chain; block 2 chained from the model's first digest.
        d1 = refCompress(blk1, iv);
        sendBlock(blk1, iv, d1, 1'b1);
        sendBlock(blk2, d1, twoExp, 1'b1);
        drain();

        // Backpressure in DONE.
        outReady = 1'b0;
        sendBlock(abcBlk, iv, abcExp, 1'b1);
        begin
            int n = 0;
            @(negedge clock);
            while (!outValid && n < 150) begin
                @(negedge clock);
                n++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            check("bpValid", 256'(outValid), 256'(1));
            check("bpDigest", digestOut, abcExp);
            check("bpInReady", 256'(inReady), 256'(0));
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        outReady = 1'b1;
        drain();

        // Reset mid-operation at round 30, then a clean run.
        sendBlock(abcBlk, iv, '0, 1'b0);
        waitRound(30);
        reset = 1'b1;
        @(negedge clock);
        check("midRstInReady", 256'(inReady), 256'(1));
        check("midRstBusy", 256'(busy), 256'(0));
        check("midRstOutValid", 256'(outValid), 256'(0));
        check("midRstRound", 256'(roundIndex), 256'(0));
        reset = 1'b0;
        sendBlock(abcBlk, iv, abcExp, 1'b1);
        drain();

        // inValid pulses while busy must be ignored.
        sendBlock(abcBlk, iv, abcExp, 1'b1);
        pulseAt(5);
        pulseAt(40);
        drain();

        // Randomized blocks against the model.
        for (int k = 0; k < 4; k++) begin
            blkR = randBlock();
            hR   = randHash();
            sendBlock(blkR, hR, refCompress(blkR, hR), 1'b1);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
